// File: rtl/scroll_display_buffer.sv
// Rotating digit message register with a WIN-digit display window and revolution tracking.
// Optional post-revolution dwell is compiled in with `define SCROLL_PAUSE_EN.
module scroll_display_buffer #(
    parameter int NIBBLES     = 8,
    parameter int WIN         = 4,
    parameter int PAUSE_TICKS = 3
) (
    input  logic                 clk3hz,
    input  logic                 clr,
    input  logic                 load,
    input  logic [4*NIBBLES-1:0] din,
    input  logic                 dir,
    input  logic                 oneshot,
    input  logic                 hold,
    output logic [4*WIN-1:0]     dataBus,
    output logic                 busy,
    output logic                 wrap
);

    localparam int SW = $clog2(NIBBLES);

    if (NIBBLES < 2 || NIBBLES > 16 || WIN < 1 || WIN > NIBBLES ||
        PAUSE_TICKS < 1 || PAUSE_TICKS > 15) begin : g_bad_params
        $error("scroll_display_buffer: parameter out of legal range");
    end

`ifdef SCROLL_PAUSE_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;
`endif

    state_t                r_state;
    state_t                w_next_state;
    logic [4*NIBBLES-1:0]  r_msg;
    logic [SW-1:0]         r_step;
    logic                  r_wrap;
    logic                  w_step_en;
    logic                  w_last_step;
    logic [4*NIBBLES-1:0]  w_rotated;
`ifdef SCROLL_PAUSE_EN
    logic [3:0]            r_pause;
    logic                  w_pause_done;
`endif

    assign w_step_en   = (r_state == S_RUN) && !hold && !load;
    assign w_last_step = (r_step == SW'(NIBBLES - 1));
    // Right rotation moves the lowest digit to the top; left moves the top digit to the bottom.
    assign w_rotated   = dir ? {r_msg[4*NIBBLES-5:0], r_msg[4*NIBBLES-1 -: 4]}
                             : {r_msg[3:0], r_msg[4*NIBBLES-1:4]};
`ifdef SCROLL_PAUSE_EN
    assign w_pause_done = (r_pause == 4'(PAUSE_TICKS - 1));
`endif

    always_ff @(posedge clk3hz or negedge clr) begin
        if (!clr) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (load) begin
            w_next_state = S_RUN;
        end else if (!hold) begin
            case (r_state)
                S_RUN: begin
                    if (w_last_step) begin
                        if (oneshot) w_next_state = S_STOP;
`ifdef SCROLL_PAUSE_EN
                        else         w_next_state = S_PAUSE;
`endif
                    end
                end
`ifdef SCROLL_PAUSE_EN
                S_PAUSE: if (w_pause_done) w_next_state = S_RUN;
`endif
                default: w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == S_RUN);
`ifdef SCROLL_PAUSE_EN
        if (r_state == S_PAUSE) busy = 1'b1;
`endif
    end

    // NOTE: the message register is reset (unlike a RAM) because dataBus must read zero during clr.
    always_ff @(posedge clk3hz or negedge clr) begin
        if (!clr) begin
            r_msg  <= '0;
            r_step <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (load) begin
                r_msg  <= din;
                r_step <= '0;
            end else if (w_step_en) begin
                r_msg  <= w_rotated;
                r_step <= w_last_step ? '0 : r_step + 1'b1;
                r_wrap <= w_last_step;
            end
        end
    end

`ifdef SCROLL_PAUSE_EN
    always_ff @(posedge clk3hz or negedge clr) begin
        if (!clr)                                 r_pause <= '0;
        else if (load)                            r_pause <= '0;
        else if (r_state == S_PAUSE && !hold)     r_pause <= w_pause_done ? 4'd0 : r_pause + 4'd1;
    end
`endif

    assign dataBus = r_msg[4*NIBBLES-1 -: 4*WIN];
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_scroll_display_buffer.sv
// Randomised and directed bench for scroll_display_buffer against a digit-queue model.
// Pause expectations follow `define SCROLL_PAUSE_EN when the bench is compiled with it.
module tb_scroll_display_buffer;

    localparam int NIBBLES = 8;
    localparam int WIN     = 4;
    localparam int PT      = 3;
`ifdef SCROLL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic                 clk3hz = 1'b0;
    logic                 clr, load, dir, oneshot, hold;
    logic [4*NIBBLES-1:0] din;
    logic [4*WIN-1:0]     dataBus;
    logic                 busy, wrap;

    int checks   = 0;
    int failures = 0;

    scroll_display_buffer #(.NIBBLES(NIBBLES), .WIN(WIN), .PAUSE_TICKS(PT)) dut (
        .clk3hz (clk3hz),
        .clr    (clr),
        .load   (load),
        .din    (din),
        .dir    (dir),
        .oneshot(oneshot),
        .hold   (hold),
        .dataBus(dataBus),
        .busy   (busy),
        .wrap   (wrap)
    );

    always #5 clk3hz = ~clk3hz;

    // Model: the message as a queue of digits (index 0 = most significant), plus a mode and counters.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_STOP} mode_t;
    logic [3:0] m_dig[$];
    mode_t      m_mode;
    int         m_steps;
    int         m_pause_left;
    bit         m_wrap;

    task automatic m_reset();
        m_dig.delete();
        for (int i = 0; i < NIBBLES; i++) m_dig.push_back(4'h0);
        m_mode = M_IDLE; m_steps = 0; m_pause_left = 0; m_wrap = 0;
    endtask

    task automatic m_tick();
        m_wrap = 0;
        if (load) begin
            m_dig.delete();
            for (int i = NIBBLES - 1; i >= 0; i--) m_dig.push_back(din[4*i +: 4]);
            m_mode = M_RUN; m_steps = 0;
        end else if (hold) begin
            // frozen
        end else if (m_mode == M_RUN) begin
            if (dir) m_dig.push_back(m_dig.pop_front());
            else     m_dig.push_front(m_dig.pop_back());
            m_steps++;
            if (m_steps == NIBBLES) begin
                m_steps = 0;
                m_wrap  = 1;
                if (oneshot)       m_mode = M_STOP;
                else if (PAUSE_EN) begin m_mode = M_PAUSE; m_pause_left = PT; end
            end
        end else if (m_mode == M_PAUSE) begin
            m_pause_left--;
            if (m_pause_left == 0) m_mode = M_RUN;
        end
    endtask

    function automatic logic [4*WIN-1:0] m_bus();
        logic [4*WIN-1:0] e;
        e = '0;
        for (int i = 0; i < WIN; i++) e[4*(WIN-1-i) +: 4] = m_dig[i];
        return e;
    endfunction

    function automatic logic m_busy();
        return (m_mode == M_RUN) || (m_mode == M_PAUSE);
    endfunction

    // Inputs change on the falling edge; outputs are compared on the following falling edge.
    task automatic cycle();
        m_tick();
        @(posedge clk3hz);
        @(negedge clk3hz);
    endtask

    task automatic test_reset();
        clr = 0; load = 1; din = 32'hDEADBEEF; dir = 0; oneshot = 0; hold = 0;
        m_reset();
        #2;
        checks++;
        if (dataBus !== 16'h0 || busy !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_state dataBus=%h busy=%b wrap=%b expected 0000/0/0", dataBus, busy, wrap);
        end
        @(posedge clk3hz); @(negedge clk3hz);
        checks++;
        if (dataBus !== 16'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL load_in_reset dataBus=%h busy=%b expected 0000/0", dataBus, busy);
        end
        clr = 1; load = 0;
        cycle();
        checks++;
        if (dataBus !== 16'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset dataBus=%h busy=%b expected 0000/0", dataBus, busy);
        end
    endtask

    task automatic test_rotate(input logic d, input logic [4*WIN-1:0] exp [4], input string nm);
        load = 1; din = 32'h41823205; dir = d; oneshot = 0; hold = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            load = 0;
            checks++;
            if (dataBus !== exp[i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s_step%0d dataBus=%h busy=%b expected %h/1", nm, i, dataBus, busy, exp[i]);
            end
        end
    endtask

    task automatic test_oneshot();
        load = 1; din = 32'h41823205; dir = 0; oneshot = 1; hold = 0;
        cycle();
        load = 0;
        for (int i = 1; i <= NIBBLES; i++) begin
            cycle();
            checks++;
            if (wrap !== (i == NIBBLES)) begin
                failures++;
                $display("FAIL oneshot_wrap step%0d wrap=%b expected %b", i, wrap, i == NIBBLES);
            end
        end
        checks++;
        if (dataBus !== 16'h4182 || busy !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_end dataBus=%h busy=%b expected 4182/0", dataBus, busy);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (dataBus !== 16'h4182 || busy !== 1'b0 || wrap !== 1'b0) begin
                failures++;
                $display("FAIL oneshot_static dataBus=%h busy=%b wrap=%b expected 4182/0/0", dataBus, busy, wrap);
            end
        end
    endtask

    task automatic test_continuous();
        load = 1; din = 32'h41823205; dir = 0; oneshot = 0; hold = 0;
        cycle();
        load = 0;
        for (int i = 0; i < NIBBLES; i++) cycle();
        checks++;
        if (wrap !== 1'b1 || dataBus !== 16'h4182 || busy !== 1'b1) begin
            failures++;
            $display("FAIL cont_wrap wrap=%b dataBus=%h busy=%b expected 1/4182/1", wrap, dataBus, busy);
        end
        for (int i = 0; i < (PAUSE_EN ? PT : 0); i++) begin
            cycle();
            checks++;
            if (dataBus !== 16'h4182 || busy !== 1'b1 || wrap !== 1'b0) begin
                failures++;
                $display("FAIL pause_dwell%0d dataBus=%h busy=%b wrap=%b expected 4182/1/0", i, dataBus, busy, wrap);
            end
        end
        cycle();
        checks++;
        if (dataBus !== 16'h5418) begin
            failures++;
            $display("FAIL cont_resume dataBus=%h expected 5418", dataBus);
        end
    endtask

    task automatic test_hold();
        load = 1; din = 32'h41823205; dir = 0; oneshot = 0; hold = 0;
        cycle();
        load = 0;
        for (int i = 0; i < 3; i++) cycle();
        hold = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (dataBus !== 16'h2054 || wrap !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL hold_frozen%0d dataBus=%h wrap=%b busy=%b expected 2054/0/1", i, dataBus, wrap, busy);
            end
        end
        hold = 0;
        for (int i = 4; i <= NIBBLES; i++) begin
            cycle();
            checks++;
            if (wrap !== (i == NIBBLES)) begin
                failures++;
                $display("FAIL hold_stepcount step%0d wrap=%b expected %b", i, wrap, i == NIBBLES);
            end
        end
        hold = 1; load = 1; din = 32'h12345678;
        cycle();
        load = 0;
        checks++;
        if (dataBus !== 16'h1234 || busy !== 1'b1) begin
            failures++;
            $display("FAIL load_in_hold dataBus=%h busy=%b expected 1234/1", dataBus, busy);
        end
        cycle();
        hold = 0;
        checks++;
        if (dataBus !== 16'h1234) begin
            failures++;
            $display("FAIL held_after_load dataBus=%h expected 1234", dataBus);
        end
    endtask

    task automatic test_clr_midrun();
        load = 1; din = 32'h41823205; dir = 1; oneshot = 0; hold = 0;
        cycle();
        load = 0;
        cycle(); cycle();
        #2 clr = 0;
        m_reset();
        #1;
        checks++;
        if (dataBus !== 16'h0 || busy !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL clr_async dataBus=%h busy=%b wrap=%b expected 0000/0/0", dataBus, busy, wrap);
        end
        @(negedge clk3hz);
        clr = 1;
        cycle();
        checks++;
        if (dataBus !== 16'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_idle dataBus=%h busy=%b expected 0000/0", dataBus, busy);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            load    = ($urandom_range(0, 15) == 0);
            din     = $urandom;
            dir     = $urandom_range(0, 1);
            hold    = ($urandom_range(0, 4) == 0);
            oneshot = ($urandom_range(0, 3) == 0);
            cycle();
            checks++;
            if (dataBus !== m_bus() || busy !== m_busy() || wrap !== m_wrap) begin
                failures++;
                $display("FAIL random_cycle%0d dataBus=%h busy=%b wrap=%b expected %h/%b/%b",
                         n, dataBus, busy, wrap, m_bus(), m_busy(), m_wrap);
            end
        end
        load = 0; hold = 0;
    endtask

    initial begin
        logic [4*WIN-1:0] exp_r [4];
        logic [4*WIN-1:0] exp_l [4];
        exp_r = '{16'h4182, 16'h5418, 16'h0541, 16'h2054};
        exp_l = '{16'h4182, 16'h1823, 16'h8232, 16'h2320};
        test_reset();
        test_rotate(1'b0, exp_r, "right");
        test_rotate(1'b1, exp_l, "left");
        test_oneshot();
        test_continuous();
        test_hold();
        test_clr_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
